// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and result channels of the ALU sequencer, bundled as one interface.
// The slave modport is the sequencer; the master modport is everything around it
// (instruction source, the ALU itself and the result sink).
interface alu_sequencer_if #(
    parameter int opcode_SIZE = 4,
    parameter int Data_WIDTH  = 8
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [opcode_SIZE-1:0] instr_op;
    logic [1:0]             instr_rd;
    logic [1:0]             instr_rs1;
    logic [1:0]             instr_rs2;
    logic [Data_WIDTH-1:0]  instr_imm;

    logic [Data_WIDTH-1:0]  alu_A;
    logic [Data_WIDTH-1:0]  alu_B;
    logic                   alu_Cin;
    logic [opcode_SIZE-1:0] alu_select;
    logic                   alu_enable;
    logic [Data_WIDTH-1:0]  alu_answer;
    logic                   alu_Cout;
    logic                   alu_negFlag;
    logic                   alu_overflowFlag;
    logic                   alu_zeroFlag;
    logic                   alu_equalFlag;
    logic                   alu_greaterthanFlag;

    logic                   res_valid;
    logic                   res_ready;
    logic [Data_WIDTH-1:0]  res_data;
    logic [1:0]             res_rd;
    logic                   res_err;
    logic [5:0]             status;
    logic                   busy;

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output instr_ready,
        output alu_A, alu_B, alu_Cin, alu_select, alu_enable,
        input  alu_answer, alu_Cout, alu_negFlag, alu_overflowFlag,
        input  alu_zeroFlag, alu_equalFlag, alu_greaterthanFlag,
        output res_valid, res_data, res_rd, res_err,
        input  res_ready,
        output status, busy
    );

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  instr_ready,
        input  alu_A, alu_B, alu_Cin, alu_select, alu_enable,
        output alu_answer, alu_Cout, alu_negFlag, alu_overflowFlag,
        output alu_zeroFlag, alu_equalFlag, alu_greaterthanFlag,
        input  res_valid, res_data, res_rd, res_err,
        output res_ready,
        input  status, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction at a time, drives an external ALU for a
// fixed settle time, writes the result into a 4-entry register file and returns
// a response. Opcode 0 loads an immediate; opcodes above 12 are rejected.
module alu_sequencer #(
    parameter int opcode_SIZE = 4,
    parameter int Data_WIDTH  = 8,
    parameter int ALU_WAIT    = 2
) (
    input  logic           clock,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam int                     CNT_W       = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [CNT_W-1:0]       LAST_WAIT   = CNT_W'(ALU_WAIT - 1);
    localparam logic [opcode_SIZE-1:0] OP_LOADI    = '0;
    localparam logic [opcode_SIZE-1:0] OP_LAST_ALU = opcode_SIZE'(12);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WRITE,
        RESP
    } state_t;

    state_t                 state;
    logic [Data_WIDTH-1:0]  regs [4];
    logic [5:0]             status_q;
    logic [Data_WIDTH-1:0]  result_answer;
    logic [5:0]             result_flags;
    logic [opcode_SIZE-1:0] op_q;
    logic [1:0]             rd_q;
    logic [Data_WIDTH-1:0]  imm_q;
    logic [CNT_W-1:0]       wait_cnt;

    logic                   instr_ready_q;
    logic                   busy_q;
    logic                   alu_enable_q;
    logic [Data_WIDTH-1:0]  alu_a_q;
    logic [Data_WIDTH-1:0]  alu_b_q;
    logic [opcode_SIZE-1:0] alu_select_q;
    logic                   res_valid_q;
    logic [Data_WIDTH-1:0]  res_data_q;
    logic [1:0]             res_rd_q;
    logic                   res_err_q;

    logic [5:0]             alu_flags;

    // Flags packed in status order: {gt, equal, zero, overflow, neg, Cout}.
    assign alu_flags = {bus.alu_greaterthanFlag, bus.alu_equalFlag, bus.alu_zeroFlag,
                        bus.alu_overflowFlag, bus.alu_negFlag, bus.alu_Cout};

    assign bus.instr_ready = instr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.alu_enable  = alu_enable_q;
    assign bus.alu_A       = alu_a_q;
    assign bus.alu_B       = alu_b_q;
    assign bus.alu_select  = alu_select_q;
    assign bus.alu_Cin     = status_q[0];
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_err     = res_err_q;
    assign bus.status      = status_q;

    // Control FSM with all datapath storage and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            status_q      <= '0;
            result_answer <= '0;
            result_flags  <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            wait_cnt      <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            alu_enable_q  <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_select_q  <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        op_q          <= bus.instr_op;
                        rd_q          <= bus.instr_rd;
                        imm_q         <= bus.instr_imm;
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (bus.instr_op == OP_LOADI) begin
                            state <= WRITE;
                        end else if (bus.instr_op <= OP_LAST_ALU) begin
                            state        <= EXEC;
                            wait_cnt     <= '0;
                            alu_enable_q <= 1'b1;
                            alu_a_q      <= regs[bus.instr_rs1];
                            alu_b_q      <= regs[bus.instr_rs2];
                            alu_select_q <= bus.instr_op;
                        end else begin
                            state       <= RESP;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                            res_data_q  <= '0;
                            res_rd_q    <= bus.instr_rd;
                        end
                    end
                end
                EXEC: begin
                    if (wait_cnt == LAST_WAIT) begin
                        result_answer <= bus.alu_answer;
                        result_flags  <= alu_flags;
                        alu_enable_q  <= 1'b0;
                        alu_a_q       <= '0;
                        alu_b_q       <= '0;
                        alu_select_q  <= '0;
                        state         <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (op_q == OP_LOADI) begin
                        regs[rd_q] <= imm_q;
                        res_data_q <= imm_q;
                    end else begin
                        regs[rd_q] <= result_answer;
                        res_data_q <= result_answer;
                        status_q   <= result_flags;
                    end
                    res_valid_q <= 1'b1;
                    res_rd_q    <= rd_q;
                    res_err_q   <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_data_q    <= '0;
                        res_rd_q      <= '0;
                        res_err_q     <= 1'b0;
                        instr_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU with a settle delay, a
// register/status model of the sequencer, fixed vectors and random instructions.
module tb_alu_sequencer;
    localparam int OPW  = 4;
    localparam int DW   = 8;
    localparam int WAIT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cycles = 0;
    int   acc_log[$];
    int   hs_log[$];

    logic [7:0]  model_regs [4];
    logic [5:0]  model_status;
    logic [13:0] alu_out;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
        logic [7:0] exp_data;
        logic [1:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
        logic [5:0] exp_status;
    } vec_t;

    vec_t vecs [8];

    alu_sequencer_if #(.opcode_SIZE(OPW), .Data_WIDTH(DW)) bus ();

    alu_sequencer #(.opcode_SIZE(OPW), .Data_WIDTH(DW), .ALU_WAIT(WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ALU behaviour: returns {gt, equal, zero, overflow, neg, Cout, answer}.
    function automatic logic [13:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        logic [8:0] wide;
        logic [7:0] ans;
        logic       ovf;
        ovf = 1'b0;
        case (op)
            4'd1:    wide = {1'b0, a} + {1'b0, b};
            4'd2:    wide = {1'b0, a} - {1'b0, b};
            4'd3:    wide = {1'b0, a & b};
            4'd4:    wide = {1'b0, a | b};
            4'd5:    wide = {1'b0, a ^ b};
            4'd6:    wide = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd7:    wide = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            4'd8:    wide = {a, 1'b0};
            4'd9:    wide = {a[0], 1'b0, a[7:1]};
            4'd10:   wide = {1'b0, ~a};
            4'd11:   wide = {1'b0, a} + 9'd1;
            4'd12:   wide = {1'b0, a} - 9'd1;
            default: wide = '0;
        endcase
        ans = wide[7:0];
        if (op == 4'd1 || op == 4'd6) ovf = (a[7] == b[7]) && (ans[7] != a[7]);
        if (op == 4'd2 || op == 4'd7) ovf = (a[7] != b[7]) && (ans[7] != a[7]);
        return {a > b, a == b, ans == 8'd0, ovf, ans[7], wide[8], ans};
    endfunction

    // The ALU result is only meaningful once enable has been held for the settle time.
    always @(posedge clock or negedge reset) begin
        if (!reset) en_cycles <= 0;
        else        en_cycles <= bus.alu_enable ? en_cycles + 1 : 0;
    end

    // Combinational ALU stand-in; drives junk while unsettled or disabled.
    always_comb begin
        alu_out = alu_ref(bus.alu_select, bus.alu_A, bus.alu_B, bus.alu_Cin);
        if (!bus.alu_enable || en_cycles < WAIT - 1) alu_out = 14'h2A5A;
    end

    assign bus.alu_answer = alu_out[7:0];
    assign {bus.alu_greaterthanFlag, bus.alu_equalFlag, bus.alu_zeroFlag,
            bus.alu_overflowFlag, bus.alu_negFlag, bus.alu_Cout} = alu_out[13:8];

    // Edge counter used to timestamp handshakes.
    always @(posedge clock) cyc <= cyc + 1;

    // Log which upcoming edge carries an accept or a response handshake.
    always begin
        @(negedge clock);
        #1;
        if (reset) begin
            if (bus.instr_valid && bus.instr_ready) acc_log.push_back(cyc);
            if (bus.res_valid && bus.res_ready)     hs_log.push_back(cyc);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer one instruction, follow it to its response, hold res_ready low for
    // 'hold' cycles, complete the handshake and update the model.
    task automatic apply_stimulus(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                  input logic [1:0] rs2, input logic [7:0] imm, input int hold,
                                  output logic [7:0] data, output logic [1:0] rdo,
                                  output logic err, output int lat);
        logic        drive_ok;
        logic        in_exec;
        logic [13:0] exp_alu;
        int          budget;
        data     = '0;
        rdo      = '0;
        err      = 1'b0;
        lat      = 0;
        drive_ok = 1'b1;
        exp_alu  = alu_ref(op, model_regs[rs1], model_regs[rs2], model_status[0]);
        @(negedge clock);
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_imm   = imm;
        bus.instr_valid = 1'b1;
        budget = 0;
        while (!bus.instr_ready && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        if (!bus.instr_ready) begin
            check_output("accept_timeout", 32'(bus.instr_ready), 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 40) begin
            in_exec = (op >= 4'd1) && (op <= 4'd12) && (lat <= WAIT);
            if (in_exec) begin
                if (!(bus.alu_enable === 1'b1 && bus.alu_A === model_regs[rs1] &&
                      bus.alu_B === model_regs[rs2] && bus.alu_select === op &&
                      bus.alu_Cin === model_status[0])) drive_ok = 1'b0;
            end else begin
                if (!(bus.alu_enable === 1'b0 && bus.alu_A === 8'd0 && bus.alu_B === 8'd0 &&
                      bus.alu_select === 4'd0 && bus.alu_Cin === model_status[0])) drive_ok = 1'b0;
            end
            if (!(bus.busy === 1'b1 && bus.instr_ready === 1'b0)) drive_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
        if (!bus.res_valid) begin
            check_output("res_valid_timeout", 32'(bus.res_valid), 32'd1);
            return;
        end
        if (!(bus.alu_enable === 1'b0 && bus.alu_A === 8'd0 && bus.alu_B === 8'd0 &&
              bus.alu_select === 4'd0)) drive_ok = 1'b0;
        data = bus.res_data;
        rdo  = bus.res_rd;
        err  = bus.res_err;
        for (int h = 0; h < hold; h++) begin
            check_output("hold_resp", 32'({bus.res_valid, bus.res_data, bus.res_rd, bus.res_err,
                                            bus.instr_ready, bus.busy}),
                         32'({1'b1, data, rdo, err, 1'b0, 1'b1}));
            @(negedge clock);
        end
        bus.res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.res_ready = 1'b0;
        check_output("alu_drive", 32'(drive_ok), 32'd1);
        check_output("done_idle", 32'({bus.instr_ready, bus.res_valid, bus.busy}), 32'(3'b100));
        if (op == 4'd0) begin
            model_regs[rd] = imm;
        end else if (op <= 4'd12) begin
            model_regs[rd] = exp_alu[7:0];
            model_status   = exp_alu[13:8];
        end
    endtask

    // Run one instruction and compare everything against the model's prediction.
    task automatic run_and_check(input string tag, input logic [3:0] op, input logic [1:0] rd,
                                 input logic [1:0] rs1, input logic [1:0] rs2,
                                 input logic [7:0] imm, input int hold);
        logic [13:0] alu;
        logic [7:0]  e_data;
        logic        e_err;
        int          e_lat;
        logic [5:0]  e_status;
        logic [7:0]  data;
        logic [1:0]  rdo;
        logic        err;
        int          lat;
        alu = alu_ref(op, model_regs[rs1], model_regs[rs2], model_status[0]);
        if (op == 4'd0) begin
            e_data = imm; e_err = 1'b0; e_lat = 2; e_status = model_status;
        end else if (op <= 4'd12) begin
            e_data = alu[7:0]; e_err = 1'b0; e_lat = WAIT + 2; e_status = alu[13:8];
        end else begin
            e_data = 8'd0; e_err = 1'b1; e_lat = 1; e_status = model_status;
        end
        apply_stimulus(op, rd, rs1, rs2, imm, hold, data, rdo, err, lat);
        check_output({tag, "_data"},   32'(data), 32'(e_data));
        check_output({tag, "_rd"},     32'(rdo),  32'(rd));
        check_output({tag, "_err"},    32'(err),  32'(e_err));
        check_output({tag, "_lat"},    32'(lat),  32'(e_lat));
        check_output({tag, "_status"}, 32'(bus.status), 32'(e_status));
    endtask

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] data;
        logic [1:0] rdo;
        logic       err;
        int         lat;
        int         budget;
        logic       seen;

        vecs[0] = '{4'd0,  2'd1, 2'd0, 2'd0, 8'd5, 8'h05, 2'd1, 1'b0, 2, 6'h00};
        vecs[1] = '{4'd0,  2'd2, 2'd0, 2'd0, 8'd3, 8'h03, 2'd2, 1'b0, 2, 6'h00};
        vecs[2] = '{4'd1,  2'd3, 2'd1, 2'd2, 8'd0, 8'h08, 2'd3, 1'b0, 4, 6'h20};
        vecs[3] = '{4'd2,  2'd0, 2'd2, 2'd1, 8'd0, 8'hFE, 2'd0, 1'b0, 4, 6'h03};
        vecs[4] = '{4'd4,  2'd0, 2'd0, 2'd0, 8'd0, 8'hFE, 2'd0, 1'b0, 4, 6'h12};
        vecs[5] = '{4'd13, 2'd1, 2'd0, 2'd0, 8'd0, 8'h00, 2'd1, 1'b1, 1, 6'h12};
        vecs[6] = '{4'd4,  2'd1, 2'd1, 2'd1, 8'd0, 8'h05, 2'd1, 1'b0, 4, 6'h10};
        vecs[7] = '{4'd15, 2'd2, 2'd0, 2'd0, 8'd0, 8'h00, 2'd2, 1'b1, 1, 6'h10};

        for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;
        model_status    = 6'd0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;
        bus.res_ready   = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_output("rst_handshake", 32'({bus.instr_ready, bus.busy, bus.res_valid}), 32'(3'b100));
        check_output("rst_alu", 32'({bus.alu_enable, bus.alu_A, bus.alu_B, bus.alu_select, bus.alu_Cin}), 32'd0);
        check_output("rst_res", 32'({bus.res_data, bus.res_rd, bus.res_err}), 32'd0);
        check_output("rst_status", 32'(bus.status), 32'd0);
        reset = 1'b1;

        // Fixed vectors: load, add, subtract, readback and illegal opcodes
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 0,
                           data, rdo, err, lat);
            check_output($sformatf("vec%0d_data", i),   32'(data), 32'(vecs[i].exp_data));
            check_output($sformatf("vec%0d_rd", i),     32'(rdo),  32'(vecs[i].exp_rd));
            check_output($sformatf("vec%0d_err", i),    32'(err),  32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d_lat", i),    32'(lat),  32'(vecs[i].exp_lat));
            check_output($sformatf("vec%0d_status", i), 32'(bus.status), 32'(vecs[i].exp_status));
        end

        // Response held by a stalled sink, then an accept right after release
        run_and_check("stall", 4'd0, 2'd3, 2'd0, 2'd0, 8'h77, 5);
        run_and_check("after_stall", 4'd4, 2'd3, 2'd3, 2'd3, 8'h00, 0);

        // Reset pulsed during the second EXEC cycle
        @(negedge clock);
        bus.instr_op = 4'd1; bus.instr_rd = 2'd3; bus.instr_rs1 = 2'd1; bus.instr_rs2 = 2'd2;
        bus.instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_output("exec_before_reset", 32'({bus.alu_enable, bus.busy}), 32'(2'b11));
        #1 reset = 1'b0;
        #1;
        check_output("async_reset", 32'({bus.alu_enable, bus.busy, bus.instr_ready, bus.alu_A}),
                     32'({1'b0, 1'b0, 1'b1, 8'd0}));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus.res_valid) seen = 1'b1;
        end
        check_output("no_resp_after_reset", 32'(seen), 32'd0);
        for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;
        model_status = 6'd0;
        for (int i = 0; i < 4; i++) begin
            run_and_check($sformatf("readback_r%0d", i), 4'd4, 2'(i), 2'(i), 2'(i), 8'h00, 0);
        end
        run_and_check("post_reset_loadi", 4'd0, 2'd2, 2'd0, 2'd0, 8'h42, 0);

        // Back-to-back instructions with instr_valid and res_ready held high
        @(negedge clock);
        acc_log.delete();
        hs_log.delete();
        bus.instr_op = 4'd0; bus.instr_rd = 2'd1; bus.instr_imm = 8'h11;
        bus.instr_valid = 1'b1;
        bus.res_ready   = 1'b1;
        budget = 0;
        while (acc_log.size() < 1 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        bus.instr_rd  = 2'd2;
        bus.instr_imm = 8'h22;
        budget = 0;
        while ((acc_log.size() < 2 || hs_log.size() < 2) && budget < 30) begin
            @(negedge clock);
            budget++;
        end
        bus.instr_valid = 1'b0;
        bus.res_ready   = 1'b0;
        if (acc_log.size() >= 2 && hs_log.size() >= 1) begin
            check_output("b2b_gap", 32'(acc_log[1]), 32'(hs_log[0] + 1));
        end else begin
            check_output("b2b_handshakes", 32'(acc_log.size()), 32'd2);
        end
        model_regs[1] = 8'h11;
        model_regs[2] = 8'h22;
        run_and_check("b2b_r1", 4'd4, 2'd1, 2'd1, 2'd1, 8'h00, 0);
        run_and_check("b2b_r2", 4'd4, 2'd2, 2'd2, 2'd2, 8'h00, 0);

        // Random instructions against the model
        for (int n = 0; n < 60; n++) begin
            run_and_check($sformatf("rand%0d", n), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters SHALL be: opcode_SIZE, default 4, ALU opcode width; Data_WIDTH, default 8, operand/result width; ALU_WAIT, default 2 (min 1), ALU settle cycles before sampling.
REQ-002 Ports SHALL be:
  clock  in  1  single clock, rising-edge
  reset  in  1  asynchronous, active-low reset
  instr_valid  in  1  instruction offered
  instr_ready  out  1  sequencer accepts instruction
  instr_op  in  opcode_SIZE  opcode (0=LOADI, 1..12=ALU ops)
  instr_rd, instr_rs1, instr_rs2  in  2 each  register indices
  instr_imm  in  Data_WIDTH  immediate for LOADI
  alu_A, alu_B  out  Data_WIDTH  ALU operands
  alu_Cin  out  1  ALU carry-in
  alu_select  out  opcode_SIZE  ALU opcode
  alu_enable  out  1  ALU enable
  alu_answer  in  Data_WIDTH  ALU result
  alu_Cout, alu_negFlag, alu_overflowFlag, alu_zeroFlag, alu_equalFlag, alu_greaterthanFlag  in  1 each  ALU flags
  res_valid  out  1  result offered
  res_ready  in  1  result consumed
  res_data  out  Data_WIDTH  result value
  res_rd  out  2  destination index
  res_err  out  1  illegal opcode
  status  out  6  {gt, equal, zero, overflow, neg, Cout}, bit0=Cout
  busy  out  1  high in any state but IDLE

Function
REQ-003 Storage SHALL be four Data_WIDTH registers r0..r3 plus the 6-bit status register; one instruction outstanding at a time.
REQ-004 FSM states SHALL be IDLE, EXEC, WRITE, RESP; instr_ready=1 only in IDLE.
REQ-005 Accept SHALL occur on a rising edge with instr_valid && instr_ready; op, rd, rs1, rs2, imm latched at that edge.
REQ-006 From IDLE on accept: op 1..12 -> EXEC; op 0 -> WRITE; op 13..max -> RESP with res_err=1.
REQ-007 EXEC SHALL last exactly ALU_WAIT cycles: alu_enable=1, alu_A=r[rs1], alu_B=r[rs2], alu_select=op, alu_Cin=status[0], all stable throughout.
REQ-008 At the edge ending the last EXEC cycle, alu_answer and six flags SHALL be captured into a result register; then WRITE.
REQ-009 Outside EXEC, alu_enable, alu_A, alu_B, alu_select SHALL be 0 and alu_Cin SHALL be status[0].
REQ-010 WRITE (one cycle) SHALL write r[rd] with the captured answer (ALU ops) or imm (LOADI); status updates from captured flags for ALU ops only; LOADI leaves status unchanged; then RESP.
REQ-011 In RESP, res_valid=1 with res_data, res_rd, res_err stable until the edge where res_ready=1, then IDLE.
REQ-012 Latency from accept edge to first res_valid cycle SHALL be ALU_WAIT+2 cycles (ALU op), 2 cycles (LOADI), 1 cycle (illegal).
REQ-013 Illegal opcode SHALL write no register, leave status unchanged, and give res_data=0, res_rd=latched rd.
REQ-014 res_err SHALL be 0 for every legal instruction.
REQ-015 rd may equal rs1/rs2; operands SHALL be the pre-write register values.
REQ-016 Earliest next accept SHALL be the cycle after the res_valid && res_ready edge; no same-cycle overlap.
REQ-017 instr_valid while busy SHALL be ignored; the offering source holds the instruction until accepted.
REQ-018 Arithmetic SHALL be ALU-owned; the sequencer passes alu_answer through unmodified, truncated to Data_WIDTH.

Reset
REQ-019 reset low SHALL immediately force IDLE, r0..r3=0, status=0, result register=0, and all outputs 0 except instr_ready=1, independent of clock.
REQ-020 Reset mid-operation SHALL abort the instruction with no register write and no response; the first rising edge after reset deasserts may accept an instruction.

Verification
REQ-021 reset; LOADI r1=5; LOADI r2=3; ADD(1) rd=3, rs1=1, rs2=2 -> res_data=8, res_rd=3, res_valid 4 cycles after accept (ALU_WAIT=2), status[5] (gt)=1, status[3] (zero)=0.
REQ-022 after REQ-021, SUB(2) rd=0, rs1=2, rs2=1 -> res_data=8'hFE, status[1] (neg)=1, r0=8'hFE.
REQ-023 op=13 rd=1 -> res_valid 1 cycle after accept, res_err=1, res_data=0, r1 still 5, status unchanged.
REQ-024 res_ready held low 5 cycles in RESP -> res_valid, res_data held, instr_ready=0 and busy=1 throughout; accept after release.
REQ-025 reset pulsed low during second EXEC cycle -> alu_enable=0 and busy=0 immediately, no response, r0..r3=0 on readback, next LOADI completes normally.
REQ-026 instr_valid held high with two back-to-back instructions, res_ready=1 -> second accepted exactly one cycle after first response handshake.
